link_writeline_fifo: RTL and testbench
======================================

LINK_WRITELINE_FIFO -- requirements
Module: link_writeline_fifo

Interface
REQ-001 Parameter ADDR_W, default 32, width of the writeline address.
REQ-002 Parameter LINE_W, default 128, width of the writeline data line.
REQ-003 Parameter DEPTH, default 4, number of queued writelines; power of two, >= 2.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 req_writeline_do  input  1  requester holds high until it sees req_writeline_done.
REQ-007 req_writeline_done  output  1  one-cycle acceptance pulse to requester.
REQ-008 req_writeline_address / req_writeline_line  input  ADDR_W / LINE_W  request payload.
REQ-009 resp_writeline_do  output  1  head entry valid toward memory side.
REQ-010 resp_writeline_done  input  1  one-cycle pulse; memory side consumed the head entry.
REQ-011 resp_writeline_address / resp_writeline_line  output  ADDR_W / LINE_W  head entry payload.
REQ-012 fifo_count  output  clog2(DEPTH)+1  number of occupied entries.
REQ-013 fifo_full / fifo_empty  output  1  fifo_count == DEPTH / fifo_count == 0.

Function
REQ-014 accept = req_writeline_do && !fifo_full && !req_writeline_done, evaluated on registered state.
REQ-015 On accept, address and line SHALL be written to the tail entry; the tail pointer increments modulo DEPTH.
REQ-016 req_writeline_done SHALL be a register equal to the previous cycle's accept: exactly one pulse per accepted request, latency 1.
REQ-017 The request held high during its done cycle SHALL NOT be accepted again; the next request is accepted no earlier than the cycle after done.
REQ-018 While fifo_full, the request SHALL be stalled with no done pulse until an entry is freed.
REQ-019 resp_writeline_do = !fifo_empty; resp payload SHALL be the head entry, driven from storage, not from the request inputs.
REQ-020 A newly accepted entry into an empty FIFO SHALL appear on the resp side the following cycle.
REQ-021 pop = resp_writeline_done && !fifo_empty; on pop the head pointer increments modulo DEPTH.
REQ-022 resp_writeline_done while fifo_empty SHALL be ignored.
REQ-023 Simultaneous accept and pop: count unchanged and both pointers advance; push is still blocked if fifo_full was set in that cycle.
REQ-024 Entries SHALL leave in strict arrival order; pointers wrap without loss.

Reset
REQ-025 Asserting rst_n low SHALL immediately clear pointers and count, and drive req_writeline_done=0, resp_writeline_do=0, fifo_empty=1, fifo_full=0, fifo_count=0.
REQ-026 Reset mid-operation SHALL discard all queued entries; a pending done pulse SHALL be suppressed.
REQ-027 Entry storage need not be reset; resp payload is don't-care while resp_writeline_do=0.

Configuration
REQ-028 Macro LINK_WRITELINE_HAZARD_EN defined: add ports hazard_address (input, ADDR_W) and hazard_match (output, 1).
REQ-029 hazard_match SHALL be combinational; it is high iff any occupied entry's address[ADDR_W-1:4] equals hazard_address[ADDR_W-1:4].
REQ-030 Macro undefined: the hazard ports and comparators SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Single write 0x1000/line A into an empty FIFO -> done pulses the cycle after the do cycle; resp_do=1 the same cycle with 0x1000/A; resp_done -> empty.
REQ-032 Resp_done held low, 5 back-to-back requests with DEPTH=4 -> 4 done pulses, fifo_full=1, 5th stalled; one resp_done -> 5th accepted, done the next cycle.
REQ-033 Issue 10 requests with random resp_done gaps -> resp addresses in issue order 0x0..0x90; pointers wrap twice; no loss or duplication.
REQ-034 Full FIFO with accept and pop in the same cycle -> pop only; count goes 4->3; request accepted the next cycle.
REQ-035 Reset asserted with 3 entries queued and done pending -> outputs at reset values at once; no done pulse after release.
REQ-036 With LINK_WRITELINE_HAZARD_EN, queued 0x2040 -> hazard_address 0x204C gives match=1 and 0x2050 gives match=0; after pop, match=0.

Source files
------------

// File: rtl/link_writeline_fifo.sv
// Writeline queue between a do/done requester and a do/done memory side; DEPTH entries, head payload driven from storage.
// Optional hazard address compare against all occupied entries when LINK_WRITELINE_HAZARD_EN is defined.
module link_writeline_fifo #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_writeline_do,
  output logic                       req_writeline_done,
  input  logic [ADDR_W-1:0]          req_writeline_address,
  input  logic [LINE_W-1:0]          req_writeline_line,
  output logic                       resp_writeline_do,
  input  logic                       resp_writeline_done,
  output logic [ADDR_W-1:0]          resp_writeline_address,
  output logic [LINE_W-1:0]          resp_writeline_line,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       fifo_full,
`ifdef LINK_WRITELINE_HAZARD_EN
  input  logic [ADDR_W-1:0]          hazard_address,
  output logic                       hazard_match,
`endif
  output logic                       fifo_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [LINE_W-1:0] line_mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q;
  logic             accept;
  logic             pop;

  assign fifo_count = count_q;
  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);

  // The done cycle blocks re-acceptance of the request still held high.
  assign accept = req_writeline_do && !fifo_full && !done_q;
  assign pop    = resp_writeline_done && !fifo_empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
    if (accept) tail_d = tail_q + 1'b1;
    if (pop)    head_d = head_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      done_q  <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_mem_q[tail_q] <= req_writeline_address;
      line_mem_q[tail_q] <= req_writeline_line;
    end
  end

  assign req_writeline_done     = done_q;
  assign resp_writeline_do      = !fifo_empty;
  assign resp_writeline_address = addr_mem_q[head_q];
  assign resp_writeline_line    = line_mem_q[head_q];

`ifdef LINK_WRITELINE_HAZARD_EN
  logic [PTR_W-1:0] haz_offs;

  // An entry is occupied when its distance from head is below the count.
  always_comb begin
    hazard_match = 1'b0;
    haz_offs     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      haz_offs = PTR_W'(i) - head_q;
      if (({1'b0, haz_offs} < count_q) &&
          (addr_mem_q[i][ADDR_W-1:4] == hazard_address[ADDR_W-1:4]))
        hazard_match = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_link_writeline_fifo.sv
// Bench for link_writeline_fifo: vector table, randomized drain ordering, reset mid-operation, optional hazard compare.
module tb_link_writeline_fifo;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_do;
  logic         req_done;
  logic [31:0]  req_addr;
  logic [127:0] req_line;
  logic         resp_do;
  logic         resp_done;
  logic [31:0]  resp_addr;
  logic [127:0] resp_line;
  logic [2:0]   cnt;
  logic         full;
  logic         empty;
`ifdef LINK_WRITELINE_HAZARD_EN
  logic [31:0]  haz_addr;
  logic         haz_match;
`endif

  always #5 clk = ~clk;

  link_writeline_fifo dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .req_writeline_do       (req_do),
    .req_writeline_done     (req_done),
    .req_writeline_address  (req_addr),
    .req_writeline_line     (req_line),
    .resp_writeline_do      (resp_do),
    .resp_writeline_done    (resp_done),
    .resp_writeline_address (resp_addr),
    .resp_writeline_line    (resp_line),
    .fifo_count             (cnt),
    .fifo_full              (full),
`ifdef LINK_WRITELINE_HAZARD_EN
    .hazard_address         (haz_addr),
    .hazard_match           (haz_match),
`endif
    .fifo_empty             (empty)
  );

  typedef struct {
    logic        rq;
    logic        rd;
    logic [31:0] addr;
    logic        push;
    logic        e_done;
    logic        e_rdo;
    logic [2:0]  e_cnt;
    logic        e_full;
    logic        e_empty;
  } vec_t;

  int errs   = 0;
  int checks = 0;
  vec_t vec [22];
  logic [31:0] sb_q [$];

  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {~a, a, a ^ 32'hA5A5A5A5, a + 32'h5A5A0000};
  endfunction

  function automatic vec_t mk(input logic rq, input logic rd, input logic [31:0] addr,
                              input logic push, input logic e_done, input logic e_rdo,
                              input logic [2:0] e_cnt, input logic e_full, input logic e_empty);
    vec_t v;
    v.rq = rq; v.rd = rd; v.addr = addr; v.push = push;
    v.e_done = e_done; v.e_rdo = e_rdo; v.e_cnt = e_cnt; v.e_full = e_full; v.e_empty = e_empty;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_pop(input string name);
    logic [31:0] a;
    if (sb_q.size() == 0) begin
      checks++;
      errs++;
      $display("FAIL %s: got pop of %0h expected no entry", name, resp_addr);
    end else begin
      a = sb_q.pop_front();
      chk({name, "_addr"}, 128'(resp_addr), 128'(a));
      chk({name, "_line"}, resp_line, line_of(a));
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_done"},  128'(req_done), 128'(0));
    chk({name, "_rdo"},   128'(resp_do),  128'(0));
    chk({name, "_cnt"},   128'(cnt),      128'(0));
    chk({name, "_full"},  128'(full),     128'(0));
    chk({name, "_empty"}, 128'(empty),    128'(1));
  endtask

  // Holds the request until done is seen; returns at the negedge where done is high.
  task automatic send(input logic [31:0] a);
    int n = 0;
    @(posedge clk); #1;
    req_do = 1'b1; req_addr = a; req_line = line_of(a);
    @(negedge clk);
    while (!req_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_done) begin
      checks++; errs++;
      $display("FAIL send_timeout: got no done expected done for %0h", a);
    end
  endtask

  initial begin
    int idx, got, cyc;
    logic pushed;

    vec[0]  = mk(1,0,32'h1000,1, 0,0,0,0,1);
    vec[1]  = mk(1,0,32'h1000,0, 1,1,1,0,0);
    vec[2]  = mk(0,1,32'h1000,0, 0,1,1,0,0);
    vec[3]  = mk(0,0,32'h0,   0, 0,0,0,0,1);
    vec[4]  = mk(1,0,32'h00,  1, 0,0,0,0,1);
    vec[5]  = mk(1,0,32'h00,  0, 1,1,1,0,0);
    vec[6]  = mk(1,0,32'h10,  1, 0,1,1,0,0);
    vec[7]  = mk(1,0,32'h10,  0, 1,1,2,0,0);
    vec[8]  = mk(1,0,32'h20,  1, 0,1,2,0,0);
    vec[9]  = mk(1,0,32'h20,  0, 1,1,3,0,0);
    vec[10] = mk(1,0,32'h30,  1, 0,1,3,0,0);
    vec[11] = mk(1,0,32'h30,  0, 1,1,4,1,0);
    vec[12] = mk(1,0,32'h40,  1, 0,1,4,1,0);
    vec[13] = mk(1,1,32'h40,  0, 0,1,4,1,0);
    vec[14] = mk(1,0,32'h40,  0, 0,1,3,0,0);
    vec[15] = mk(1,0,32'h40,  0, 1,1,4,1,0);
    vec[16] = mk(0,1,32'h0,   0, 0,1,4,1,0);
    vec[17] = mk(0,1,32'h0,   0, 0,1,3,0,0);
    vec[18] = mk(0,1,32'h0,   0, 0,1,2,0,0);
    vec[19] = mk(0,1,32'h0,   0, 0,1,1,0,0);
    vec[20] = mk(0,1,32'h0,   0, 0,0,0,0,1);
    vec[21] = mk(0,0,32'h0,   0, 0,0,0,0,1);

    rst_n = 1'b0; req_do = 1'b0; req_addr = '0; req_line = '0; resp_done = 1'b0;
`ifdef LINK_WRITELINE_HAZARD_EN
    haz_addr = '0;
`endif
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      req_do = vec[i].rq; req_addr = vec[i].addr; req_line = line_of(vec[i].addr);
      resp_done = vec[i].rd;
      if (vec[i].push) sb_q.push_back(vec[i].addr);
      @(negedge clk);
      chk($sformatf("v%0d_done", i),  128'(req_done), 128'(vec[i].e_done));
      chk($sformatf("v%0d_rdo", i),   128'(resp_do),  128'(vec[i].e_rdo));
      chk($sformatf("v%0d_cnt", i),   128'(cnt),      128'(vec[i].e_cnt));
      chk($sformatf("v%0d_full", i),  128'(full),     128'(vec[i].e_full));
      chk($sformatf("v%0d_empty", i), 128'(empty),    128'(vec[i].e_empty));
      if (vec[i].rd && resp_do) chk_pop($sformatf("v%0d_pop", i));
    end
    chk("table_sb_empty", 128'(sb_q.size()), 128'(0));

    // Ten requests against a randomly stalling memory side; order must hold across wraps.
    idx = 0; got = 0; cyc = 0; pushed = 1'b0;
    while (got < 10 && cyc < 2000) begin
      @(posedge clk); #1;
      req_do = (idx < 10);
      req_addr = 32'(idx) * 32'h10;
      req_line = line_of(req_addr);
      if (idx < 10 && !pushed) begin
        sb_q.push_back(req_addr);
        pushed = 1'b1;
      end
      resp_done = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      if (req_done) begin
        idx++;
        pushed = 1'b0;
      end
      if (resp_done && resp_do) begin
        chk_pop($sformatf("rnd%0d", got));
        got++;
      end
      cyc++;
    end
    chk("rnd_popped", 128'(got), 128'(10));
    @(posedge clk); #1;
    req_do = 1'b0; resp_done = 1'b0;
    @(negedge clk);
    chk_idle("rnd_drained");

    // Reset with three entries queued and a done pulse in flight.
    send(32'h300); send(32'h310); send(32'h320);
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle("midrst");
    req_do = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle($sformatf("postrst%0d", i));
    end

`ifdef LINK_WRITELINE_HAZARD_EN
    send(32'h2040);
    @(posedge clk); #1;
    req_do = 1'b0; haz_addr = 32'h204C;
    #1;
    chk("haz_same_line", 128'(haz_match), 128'(1));
    haz_addr = 32'h2050;
    #1;
    chk("haz_next_line", 128'(haz_match), 128'(0));
    haz_addr = 32'h204C;
    resp_done = 1'b1;
    @(posedge clk); #1;
    resp_done = 1'b0;
    #1;
    chk("haz_after_pop", 128'(haz_match), 128'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
